// File: rtl/nn_seq_pkg.sv
// Shared types for the NN layer sequencer: FSM state encoding and error codes.
package nn_seq_pkg;

  typedef enum logic [3:0] {
    IDLE, INIT_REQ, INIT_WAIT, LOAD_REQ, LOAD_WAIT,
    PROC_REQ, PROC_WAIT, WRITE_REQ, WRITE_WAIT, DONE, ERROR
  } seq_state_t;

  typedef logic [1:0] err_code_t;
  localparam err_code_t ERR_NONE   = 2'd0;
  localparam err_code_t ERR_LAYERS = 2'd1;
  localparam err_code_t ERR_WDOG   = 2'd2;

  function automatic logic is_busy_state(input seq_state_t s);
    return !(s inside {IDLE, DONE, ERROR});
  endfunction

  function automatic logic is_wait_state(input seq_state_t s);
    return s inside {INIT_WAIT, LOAD_WAIT, PROC_WAIT, WRITE_WAIT};
  endfunction

endpackage

// File: rtl/nn_seq_watchdog.sv
// Per-wait cycle counter; o_expired flags the WDOG_CYCLES-th consecutive enabled cycle.
module nn_seq_watchdog #(
  parameter int WDOG_CYCLES = 4096
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);
  localparam int W = (WDOG_CYCLES > 2) ? $clog2(WDOG_CYCLES) : 1;

  logic [W-1:0] r_cnt;

  // The entry cycle counts as the first cycle, so the limit compare is one less.
  assign o_expired = i_enable && (r_cnt == W'(WDOG_CYCLES - 1));

  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear) r_cnt <= '0;
    else if (i_enable && !o_expired) r_cnt <= r_cnt + 1'b1;
  end
endmodule

// File: rtl/nn_layer_sequencer.sv
// Primary layer-walking FSM of the NN accelerator.
// Optional watchdog on every *_WAIT state when NN_SEQ_WATCHDOG_EN is defined.
module nn_layer_sequencer
  import nn_seq_pkg::*;
#(
  parameter int WDOG_CYCLES = 4096,
  parameter int CNT_W       = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic             i_registers_initialized,
  input  logic             i_data_loaded,
  input  logic             i_data_processed,
  input  logic             i_output_written,
  input  logic [7:0]       i_totalLayerNumber,
  output logic             o_begin_initialize_registers,
  output logic             o_begin_load_data,
  output logic             o_begin_process_data,
  output logic             o_begin_write_output,
  output logic [7:0]       o_stage,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err,
  output logic [1:0]       o_err_code,
  output logic [CNT_W-1:0] o_run_cycles
);
  seq_state_t r_state, w_next;
  err_code_t  w_err, r_err_code;
  logic [7:0] r_stage, r_layer_total;
  logic [CNT_W-1:0] r_run;
  logic r_b_init, r_b_load, r_b_proc, r_b_write, r_busy, r_done, r_err;
  logic w_accept, w_wdog_expired;

  if (WDOG_CYCLES < 2) begin : g_bad_wdog
    $error("WDOG_CYCLES must be at least 2");
  end

`ifdef NN_SEQ_WATCHDOG_EN
  logic w_wdog_clear;
  assign w_wdog_clear = is_wait_state(w_next) && (w_next != r_state);
  nn_seq_watchdog #(.WDOG_CYCLES(WDOG_CYCLES)) u_wdog (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_clear  (w_wdog_clear),
    .i_enable (is_wait_state(r_state)),
    .o_expired(w_wdog_expired)
  );
`else
  assign w_wdog_expired = 1'b0;
`endif

  assign w_accept = i_start && !is_busy_state(r_state);

  always_comb begin
    w_next = r_state;
    w_err  = ERR_NONE;
    case (r_state)
      IDLE, DONE, ERROR: if (i_start) w_next = INIT_REQ;
      INIT_REQ:   w_next = INIT_WAIT;
      INIT_WAIT:
        if (i_registers_initialized) begin
          if (i_totalLayerNumber < 8'd2) begin
            w_next = ERROR;
            w_err  = ERR_LAYERS;
          end else w_next = LOAD_REQ;
        end
      LOAD_REQ:   w_next = LOAD_WAIT;
      LOAD_WAIT:  if (i_data_loaded) w_next = PROC_REQ;
      PROC_REQ:   w_next = PROC_WAIT;
      PROC_WAIT:
        if (i_data_processed)
          w_next = (r_stage < r_layer_total - 8'd1) ? LOAD_REQ : WRITE_REQ;
      WRITE_REQ:  w_next = WRITE_WAIT;
      WRITE_WAIT: if (i_output_written) w_next = DONE;
      default:    w_next = IDLE;
    endcase
    // A completion pulse arriving in the expiry cycle still wins.
    if (w_wdog_expired && w_next == r_state) begin
      w_next = ERROR;
      w_err  = ERR_WDOG;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state       <= IDLE;
      r_b_init      <= 1'b0;
      r_b_load      <= 1'b0;
      r_b_proc      <= 1'b0;
      r_b_write     <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_err         <= 1'b0;
      r_err_code    <= ERR_NONE;
      r_stage       <= 8'd0;
      r_layer_total <= 8'd0;
      r_run         <= '0;
    end else begin
      r_state   <= w_next;
      r_b_init  <= (w_next == INIT_REQ);
      r_b_load  <= (w_next == LOAD_REQ);
      r_b_proc  <= (w_next == PROC_REQ);
      r_b_write <= (w_next == WRITE_REQ);
      r_busy    <= is_busy_state(w_next);
      r_done    <= (w_next == DONE);
      r_err     <= (w_next == ERROR);
      if (w_accept) begin
        r_stage    <= 8'd0;
        r_err_code <= ERR_NONE;
        r_run      <= '0;
      end else begin
        if (w_next == ERROR && r_state != ERROR) r_err_code <= w_err;
        if (w_next == LOAD_REQ)
          r_stage <= (r_state == INIT_WAIT) ? 8'd1 : r_stage + 8'd1;
        if (r_busy && r_run != '1) r_run <= r_run + 1'b1;
      end
      if (r_state == INIT_WAIT && i_registers_initialized)
        r_layer_total <= i_totalLayerNumber;
    end
  end

  assign o_begin_initialize_registers = r_b_init;
  assign o_begin_load_data            = r_b_load;
  assign o_begin_process_data         = r_b_proc;
  assign o_begin_write_output         = r_b_write;
  assign o_stage                      = r_stage;
  assign o_busy                       = r_busy;
  assign o_done                       = r_done;
  assign o_err                        = r_err;
  assign o_err_code                   = r_err_code;
  assign o_run_cycles                 = r_run;
endmodule
